// File: rtl/spad_write_arbiter.sv
// ---------------------------------------------------------------------------
// spad_write_arbiter
//   Shares the single PE scratchpad write port between NUM_REQ read
//   controllers (filter, ifmap, psum). A requester raises req while its input
//   FIFO is non-empty. The arbiter selects one round-robin, registers its
//   burst length, and holds a one-hot grant until the burst completes, the
//   FIFO drains, or reset. There is always one idle cycle between grants.
//
//   Optional feature macro: SPAD_ARB_STATS_EN
//     Adds per-requester 16-bit saturating beat counters (stat_beats) with a
//     synchronous clear (stat_clr).
//
// Ports
//   clk        in   clock
//   rstn       in   asynchronous active-low reset
//   en         in   enable; 0 freezes all state and masks grant/beat/burst_done
//   req        in   [NUM_REQ]            req[i] = ~empty of requester i
//   burst_len  in   [NUM_REQ*CONFIG_BIT] words per grant, field i at i*CONFIG_BIT
//   spad_busy  in   spad cannot accept a write this cycle
//   grant      out  [NUM_REQ]            one-hot write grant
//   grant_id   out  [$clog2(NUM_REQ)]    current owner (valid while busy)
//   beat       out  one word is written this cycle
//   burst_done out  pulse on the final beat of a full burst
//   busy       out  arbiter owns a grant
//   stat_clr   in   (SPAD_ARB_STATS_EN) synchronous clear of beat counters
//   stat_beats out  (SPAD_ARB_STATS_EN) [NUM_REQ*16] per-requester beat counts
// ---------------------------------------------------------------------------
module spad_write_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned CONFIG_BIT = 5,
    localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*CONFIG_BIT-1:0] burst_len,
    input  logic                          spad_busy,
`ifdef SPAD_ARB_STATS_EN
    input  logic                          stat_clr,
    output logic [NUM_REQ*16-1:0]         stat_beats,
`endif
    output logic [NUM_REQ-1:0]            grant,
    output logic [ID_W-1:0]               grant_id,
    output logic                          beat,
    output logic                          burst_done,
    output logic                          busy
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                state_q, state_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CONFIG_BIT:0]   cnt_q, cnt_d;
    logic [CONFIG_BIT-1:0] len_q, len_d;

    // Round-robin pick: first requester at or after rr_ptr+1, wrapping.
    logic [ID_W-1:0]             pick_id;
    logic                        pick_found;
    logic [NUM_REQ-1:0]          req_sh;
    int unsigned                 scan_idx;
    logic [NUM_REQ*CONFIG_BIT-1:0] len_sh;
    logic [CONFIG_BIT-1:0]       pick_len;

    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        req_sh     = '0;
        scan_idx   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            req_sh   = req >> scan_idx;
            if (!pick_found && req_sh[0]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        len_sh   = burst_len >> (32'(pick_id) * CONFIG_BIT);
        pick_len = len_sh[CONFIG_BIT-1:0];
    end

    // Owner's request and final-beat detection.
    logic [NUM_REQ-1:0] own_sh;
    logic               own_req;
    logic               last_word;

    always_comb begin
        own_sh    = req >> id_q;
        own_req   = own_sh[0];
        last_word = (cnt_q + (CONFIG_BIT+1)'(1)) == {1'b0, len_q};
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        grant      = '0;
        beat       = 1'b0;
        burst_done = 1'b0;
        busy       = (state_q == StGrant);

        unique case (state_q)
            StIdle: begin
                // spad_busy deliberately does not gate selection.
                if (en && pick_found) begin
                    id_d    = pick_id;
                    len_d   = (pick_len == '0) ? CONFIG_BIT'(1) : pick_len;
                    cnt_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (en) begin
                    grant = NUM_REQ'(1) << id_q;
                    beat  = own_req & ~spad_busy;
                    if (beat && last_word) begin
                        burst_done = 1'b1;
                        rr_ptr_d   = id_q;
                        state_d    = StIdle;
                    end else if (beat) begin
                        cnt_d = cnt_q + (CONFIG_BIT+1)'(1);
                    end else if (!own_req) begin
                        // FIFO drained mid-burst: give up the port, no done pulse.
                        rr_ptr_d = id_q;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            id_q     <= '0;
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
            cnt_q    <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
        end
    end

    assign grant_id = id_q;

`ifdef SPAD_ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                stat_q[i] <= '0;
            end else if (stat_clr) begin
                stat_q[i] <= '0;
            end else if (beat && (id_q == ID_W'(i)) && (stat_q[i] != 16'hFFFF)) begin
                stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
        assign stat_beats[i*16 +: 16] = stat_q[i];
    end
`endif

endmodule
